// File: rtl/hud_pkg.sv
// Shared types and helpers for the HUD score/coin/timer BCD conversion path.
package hud_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam bcd_digit_t BCD_ADD3_THRESHOLD = 4'd5;

    // 10^n, evaluated at elaboration for the saturation compare.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
    import hud_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);

    assign d_o = (d_i >= BCD_ADD3_THRESHOLD) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter for the HUD digit renderers; one bit per cycle,
// outputs held stable between done pulses.
module score_bcd_converter
    import hud_pkg::*;
#(
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 6,
    parameter int MSD_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    parameter int CNT_W     = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BIN_WIDTH-1:0]       value,
    output logic                       busy,
    output logic                       done,
    output logic [DIGITS-1:0][3:0]     digits,
    output logic [MSD_W-1:0]           msd_index,
    output logic                       overflow
);

    conv_state_t               state_q, state_d;
    logic [DIGITS-1:0][3:0]    scratch_q, scratch_d;
    logic [BIN_WIDTH-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ovfp_q, ovfp_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [DIGITS-1:0][3:0]    digits_q, digits_d;
    logic [MSD_W-1:0]          msd_q, msd_d;
    logic                      ovf_q, ovf_d;

    logic [DIGITS-1:0][3:0]    adj;
    logic [DIGITS-1:0][3:0]    disp;
    logic [MSD_W-1:0]          msd_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scratch_q[g]),
            .d_o (adj[g])
        );
    end

    assign disp = ovfp_q ? {DIGITS{4'd9}} : scratch_q;

    // Highest nonzero digit of what will be displayed; 0 for an all-zero value.
    always_comb begin
        msd_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp[i] != 4'd0) msd_c = MSD_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        ovfp_d    = ovfp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        digits_d  = digits_q;
        msd_d     = msd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = value;
                    scratch_d = '0;
                    ovfp_d    = (64'(value) >= pow10(DIGITS));
                    cnt_d     = CNT_W'(BIN_WIDTH - 1);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Bits pushed past the top digit fall off; overflow was decided at load.
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                digits_d = disp;
                msd_d    = msd_c;
                ovf_d    = ovfp_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ovfp_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            digits_q  <= '0;
            msd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            ovfp_q    <= ovfp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            digits_q  <= digits_d;
            msd_q     <= msd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign digits    = digits_q;
    assign msd_index = msd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: directed cases plus random values vs a decimal model.
module tb_score_bcd_converter;

    localparam int BW  = 20;
    localparam int ND  = 6;
    localparam int MW  = 3;
    localparam int LAT = BW + 2;  // negedge of accept decision to negedge showing done

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [BW-1:0]        value = '0;
    logic                 busy, done, overflow;
    logic [ND-1:0][3:0]   digits;
    logic [MW-1:0]        msd_index;

    score_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .digits    (digits),
        .msd_index (msd_index),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned v;
        int          due;
    } exp_t;

    exp_t               q[$];
    int                 cyc = 0;
    int                 nvec = 0;
    int                 nmis = 0;
    logic [ND-1:0][3:0] hold_d = '0;
    logic               hold_o = 1'b0;
    logic [MW-1:0]      hold_m = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Decimal reference: plain division, saturating at 10^ND.
    task automatic ref_model(input int unsigned v, output logic [ND-1:0][3:0] d,
                             output logic o, output logic [MW-1:0] m);
        int unsigned x;
        o = (v >= 1000000);
        m = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            d[i] = o ? 4'd9 : 4'(x % 10);
            x    = x / 10;
            if (d[i] != 0) m = MW'(i);
        end
    endtask

    always @(negedge clk) begin
        logic [ND-1:0][3:0] ed;
        logic               eo;
        logic [MW-1:0]      em;
        logic               exp_busy;
        exp_t               e;
        if (reset) begin
            q.delete();
            hold_d = '0;
            hold_o = 1'b0;
            hold_m = '0;
            chk("reset_outputs", {busy, done, overflow, msd_index, digits}, '0);
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    ref_model(e.v, ed, eo, em);
                    chk("done_latency", cyc, e.due);
                    chk("digits", digits, ed);
                    chk("overflow", overflow, eo);
                    if (!eo) chk("msd_index", msd_index, em);
                    hold_d = ed;
                    hold_o = eo;
                    hold_m = em;
                end
            end else begin
                chk("held_digits", {overflow, digits}, {hold_o, hold_d});
                if (!hold_o) chk("held_msd", msd_index, hold_m);
            end
            if (q.size() > 0 && cyc > q[0].due) begin
                chk("done_timeout", 0, 1);
                void'(q.pop_front());
            end
            exp_busy = (q.size() > 0) && (cyc < q[0].due);
            chk("busy", busy, exp_busy);
            if (start && !exp_busy) begin
                e.v   = value;
                e.due = cyc + LAT;
                q.push_back(e);
            end
        end
    end

    task automatic conv(input logic [BW-1:0] v, input int gap);
        @(posedge clk); #1;
        start = 1'b1;
        value = v;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (BW + 1 + gap) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        conv(20'd0, 1);
        conv(20'd123456, 1);

        // start held high: second value accepted immediately after the first completes
        @(posedge clk); #1;
        start = 1'b1;
        value = 20'd999999;
        @(posedge clk); #1;
        value = 20'd1000000;
        repeat (BW + 2) @(posedge clk);
        #1 start = 1'b0;
        repeat (BW + 3) @(posedge clk);

        // re-pulses while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1;
        value = 20'd42;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; value = 20'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; value = 20'd9;
        @(posedge clk); #1 start = 1'b0;
        repeat (BW + 2) @(posedge clk);

        // abort mid-conversion with reset
        conv(20'd777, 1);
        @(posedge clk); #1;
        start = 1'b1;
        value = 20'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (BW + 5) @(posedge clk);
        conv(20'd5, 0);

        conv(20'd999999, 0);
        conv(20'd1000000, 2);
        conv(20'd1048575, 0);
        conv(20'd100000, 1);
        for (int i = 0; i < 40; i++) begin
            conv(20'($urandom_range(0, 1048575)), int'($urandom_range(0, 3)));
        end

        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
